slot_store_ctrl: RTL and testbench

Parametrised slot-storage controller: successor to the fixed two-chart storage manager, serving any number of fixed-width records (charts, play records) from one single-port synchronous RAM. After reset it preloads a configurable number of slots from an init image source. It then serves read/write/clear requests over a valid/ready handshake with a per-slot occupancy map. It sits between the game/menu FSMs and block RAM; unoccupied or invalid slots read back as all-zero defaults.

---
 rtl/storage_pkg.sv | 24 ++
 rtl/slot_ram.sv | 28 ++
 rtl/slot_store_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_slot_store_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/storage_pkg.sv
// Shared types for the slot-storage controller: request opcodes, controller
// states and the slot-index width helper.
package storage_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_CLEAR = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WAIT1 = 2'd2,
    ST_WAIT2 = 2'd3
  } state_e;

  // A single-slot store still needs a one-bit address.
  function automatic int idx_w(input int slots);
    return (slots > 1) ? $clog2(slots) : 1;
  endfunction

endpackage

// File: rtl/slot_ram.sv
// Single-port record store with a registered read port and no reset;
// the read register holds its value until the next enabled read.
module slot_ram #(
  parameter int SLOTS  = 16,
  parameter int DATA_W = 3384,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [SLOTS];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem_q[addr] <= wdata;
      else    rdata_q     <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/slot_store_ctrl.sv
// Slot-storage controller: preloads init images, then serialises
// read/write/clear requests against one RAM, masking empty slots via used_map.
//
// state | meaning
// INIT  | copying init images into slots 1..INIT_SLOTS
// IDLE  | ready for a request
// WAIT1 | read issued, RAM word not yet available
// WAIT2 | last wait cycle; response registered on exit
module slot_store_ctrl
  import storage_pkg::*;
#(
  parameter int SLOTS      = 16,
  parameter int DATA_W     = 3384,
  parameter int ID_W       = 8,
  parameter int INIT_SLOTS = 2
) (
  input  logic                         clk,
  input  logic                         sys_rst,
  output logic [idx_w(SLOTS)-1:0]      init_idx,
  input  logic [DATA_W-1:0]            init_data,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [1:0]                   req_op,
  input  logic [ID_W-1:0]              req_id,
  input  logic [DATA_W-1:0]            req_data,
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            rsp_data,
  output logic                         rsp_hit,
  output logic                         rsp_err,
  output logic                         busy,
  output logic [SLOTS-1:0]             used_map,
  output logic [$clog2(SLOTS+1)-1:0]   used_cnt
);

  localparam int IDX_W = idx_w(SLOTS);
  localparam int CNT_W = $clog2(SLOTS+1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   init_idx_q, init_idx_d;
  logic [SLOTS-1:0]   used_q, used_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pend_rd_q, pend_rd_d;
  logic               pend_hit_q, pend_hit_d;
  logic               pend_err_q, pend_err_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_hit_q, rsp_hit_d;
  logic               rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;

  logic               ram_en, ram_we;
  logic [IDX_W-1:0]   ram_addr;
  logic [DATA_W-1:0]  ram_wdata, ram_rdata;

  logic [31:0]        id_ext;
  logic [IDX_W-1:0]   req_addr;
  logic               req_ok, slot_used;
  op_e                op;

  assign op        = op_e'(req_op);
  assign id_ext    = 32'(req_id);
  assign req_ok    = (id_ext != 32'd0) && (id_ext <= 32'(SLOTS)) && (op != OP_RSVD);
  assign req_addr  = IDX_W'(id_ext - 32'd1);
  assign slot_used = used_q[req_addr];

  always_comb begin
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    used_d      = used_q;
    cnt_d       = cnt_q;
    pend_rd_d   = pend_rd_q;
    pend_hit_d  = pend_hit_q;
    pend_err_d  = pend_err_q;
    rsp_valid_d = 1'b0;
    rsp_hit_d   = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = '0;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = req_addr;
    ram_wdata   = req_data;

    case (state_q)
      ST_INIT: begin
        ram_en             = 1'b1;
        ram_we             = 1'b1;
        ram_addr           = init_idx_q;
        ram_wdata          = init_data;
        used_d[init_idx_q] = 1'b1;
        cnt_d              = cnt_q + CNT_W'(1);
        if (init_idx_q == IDX_W'(INIT_SLOTS - 1)) begin
          state_d    = ST_IDLE;
          init_idx_d = '0;
        end else begin
          init_idx_d = init_idx_q + IDX_W'(1);
        end
      end

      ST_IDLE: begin
        if (req_valid) begin
          pend_hit_d = req_ok && slot_used;
          pend_err_d = !req_ok;
          pend_rd_d  = (op == OP_READ) || (op == OP_RSVD);
          state_d    = ((op == OP_WRITE) || (op == OP_CLEAR)) ? ST_WAIT2 : ST_WAIT1;
          if (req_ok) begin
            case (op)
              OP_READ: ram_en = 1'b1;
              OP_WRITE: begin
                ram_en           = 1'b1;
                ram_we           = 1'b1;
                used_d[req_addr] = 1'b1;
                if (!slot_used) cnt_d = cnt_q + CNT_W'(1);
              end
              OP_CLEAR: begin
                used_d[req_addr] = 1'b0;
                if (slot_used) cnt_d = cnt_q - CNT_W'(1);
              end
              default: ;
            endcase
          end
        end
      end

      ST_WAIT1: state_d = ST_WAIT2;

      ST_WAIT2: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b1;
        rsp_hit_d   = pend_hit_q;
        rsp_err_d   = pend_err_q;
        // Empty slots may hold stale words from before a reset; mask them.
        rsp_data_d  = (pend_rd_q && pend_hit_q) ? ram_rdata : '0;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q     <= (INIT_SLOTS > 0) ? ST_INIT : ST_IDLE;
      init_idx_q  <= '0;
      used_q      <= '0;
      cnt_q       <= '0;
      pend_rd_q   <= 1'b0;
      pend_hit_q  <= 1'b0;
      pend_err_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      used_q      <= used_d;
      cnt_q       <= cnt_d;
      pend_rd_q   <= pend_rd_d;
      pend_hit_q  <= pend_hit_d;
      pend_err_q  <= pend_err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  slot_ram #(
    .SLOTS  (SLOTS),
    .DATA_W (DATA_W),
    .AW     (IDX_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign init_idx  = init_idx_q;
  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_INIT);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_err   = rsp_err_q;
  assign used_map  = used_q;
  assign used_cnt  = cnt_q;

endmodule

// File: tb/tb_slot_store_ctrl.sv
// Directed bench for slot_store_ctrl: a slot/occupancy model predicts each
// response, which is queued at accept and compared when rsp_valid pulses.
module tb_slot_store_ctrl;

  localparam int DW    = 3384;
  localparam int SLOTS = 16;
  localparam int IDW   = 8;
  localparam int IW    = $clog2(SLOTS);
  localparam int CW    = $clog2(SLOTS+1);

  logic            clk = 1'b0;
  logic            sys_rst = 1'b1;
  logic [IW-1:0]   init_idx;
  logic [DW-1:0]   init_data;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [1:0]      req_op = 2'd0;
  logic [IDW-1:0]  req_id = '0;
  logic [DW-1:0]   req_data = '0;
  logic            rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            rsp_hit;
  logic            rsp_err;
  logic            busy;
  logic [SLOTS-1:0] used_map;
  logic [CW-1:0]   used_cnt;

  typedef struct {
    logic [DW-1:0] data;
    logic          hit;
    logic          err;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] img   [SLOTS];
  logic [DW-1:0] mem_m [0:SLOTS+1];
  bit            used_m[0:SLOTS+1];
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign init_data = img[init_idx];

  slot_store_ctrl #(
    .SLOTS(SLOTS), .DATA_W(DW), .ID_W(IDW), .INIT_SLOTS(2)
  ) dut (
    .clk(clk), .sys_rst(sys_rst), .init_idx(init_idx), .init_data(init_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_id(req_id), .req_data(req_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_hit(rsp_hit), .rsp_err(rsp_err),
    .busy(busy), .used_map(used_map), .used_cnt(used_cnt)
  );

  function automatic logic [DW-1:0] pat(input logic [7:0] b);
    logic [DW-1:0] r;
    for (int i = 0; i < DW/8; i++) r[i*8 +: 8] = b ^ 8'(i);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed[63:0]=%0h expected[63:0]=%0h", tag, obs[63:0], expv[63:0]);
    end
  endtask

  // Response monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!sys_rst) begin
      if (rsp_valid) begin
        chk("rsp_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chkd("rsp_data", rsp_data, e.data);
          chk("rsp_hit", 64'(rsp_hit), 64'(e.hit));
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
          chk("rsp_latency", 64'(cyc), 64'(e.cyc));
        end
      end else begin
        chkd("rsp_data_idle", rsp_data, '0);
      end
    end
  end

  // Holds reset for n edges, then checks the reset state and the two init cycles.
  task automatic do_reset(input int n);
    sys_rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_used_map", 64'(used_map), 64'd0);
    chk("rst_used_cnt", 64'(used_cnt), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_init_idx", 64'(init_idx), 64'd0);
    sys_rst = 1'b0;
    sb.delete();
    for (int i = 0; i <= SLOTS+1; i++) used_m[i] = 1'b0;
    @(posedge clk); #1;
    chk("init1_busy", 64'(busy), 64'd1);
    chk("init1_used_map", 64'(used_map), 64'h1);
    @(posedge clk); #1;
    chk("init2_busy", 64'(busy), 64'd0);
    chk("init2_ready", 64'(req_ready), 64'd1);
    chk("init2_used_map", 64'(used_map), 64'h3);
    chk("init2_used_cnt", 64'(used_cnt), 64'd2);
    used_m[1] = 1'b1; mem_m[1] = img[0];
    used_m[2] = 1'b1; mem_m[2] = img[1];
  endtask

  task automatic do_req(input logic [1:0] op, input int id, input logic [DW-1:0] d,
                        input bit push, input bit keep, output int acc);
    exp_t e;
    bit   ok;
    int   n;
    ok    = (id >= 1) && (id <= SLOTS) && (op != 2'd3);
    e.err = !ok;
    e.hit = ok && used_m[id];
    e.data = (ok && op == 2'd0 && e.hit) ? mem_m[id] : '0;
    req_valid = 1'b1;
    req_op    = op;
    req_id    = IDW'(id);
    req_data  = d;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    acc = cyc;
    if (!req_ready) begin
      chk("accept_wait_ready", 64'(req_ready), 64'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    acc   = cyc;
    e.cyc = cyc + ((op == 2'd1 || op == 2'd2) ? 1 : 2);
    if (push) sb.push_back(e);
    if (ok && op == 2'd1) begin mem_m[id] = d; used_m[id] = 1'b1; end
    if (ok && op == 2'd2) used_m[id] = 1'b0;
    if (!keep) req_valid = 1'b0;
  endtask

  initial begin
    int a0, a1;
    for (int i = 0; i < SLOTS; i++) img[i] = pat(8'(8'hA0 + i));
    for (int i = 0; i <= SLOTS+1; i++) mem_m[i] = '0;

    do_reset(3);

    do_req(2'd0, 1, '0, 1, 0, a0);
    do_req(2'd0, 2, '0, 1, 0, a0);

    do_req(2'd1, 5, pat(8'h5A), 1, 0, a0);
    chk("wr5_used_cnt", 64'(used_cnt), 64'd3);
    chk("wr5_used_map", 64'(used_map), 64'h13);
    do_req(2'd0, 5, '0, 1, 0, a0);
    do_req(2'd0, 6, '0, 1, 0, a0);
    do_req(2'd1, 5, pat(8'h77), 1, 0, a0);
    chk("rewrite_used_cnt", 64'(used_cnt), 64'd3);

    do_req(2'd2, 1, '0, 1, 0, a0);
    chk("clr1_used_cnt", 64'(used_cnt), 64'd2);
    do_req(2'd0, 1, '0, 1, 0, a0);
    do_req(2'd2, 1, '0, 1, 0, a0);
    chk("clr1_again_used_cnt", 64'(used_cnt), 64'd2);

    do_req(2'd0, 0, '0, 1, 0, a0);
    do_req(2'd0, SLOTS+1, '0, 1, 0, a0);
    do_req(2'd3, 3, '0, 1, 0, a0);
    do_req(2'd1, 0, pat(8'hEE), 1, 0, a0);
    chk("invalid_used_map", 64'(used_map), 64'h12);
    do_req(2'd0, SLOTS, '0, 1, 0, a0);

    // Continuous valid, alternating ops: accept spacing 2 after a write, 3 after a read.
    do_req(2'd1, 7, pat(8'h31), 1, 1, a0);
    for (int i = 0; i < 3; i++) begin
      do_req(2'd0, 7, '0, 1, 1, a1);
      chk("gap_after_write", 64'(a1 - a0), 64'd2);
      do_req(2'd1, 7 + i + 1, pat(8'(8'h40 + i)), 1, 1, a0);
      chk("gap_after_read", 64'(a0 - a1), 64'd3);
    end
    do_req(2'd0, 9, '0, 1, 0, a1);
    chk("gap_last_write", 64'(a1 - a0), 64'd2);

    // Reset while a read sits in WAIT1: its response must never appear.
    do_req(2'd0, 5, '0, 0, 0, a0);
    do_reset(1);
    do_req(2'd0, 1, '0, 1, 0, a0);
    do_req(2'd0, 5, '0, 1, 0, a0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
